// File: rtl/doce_mac_tbl_pkg.sv
// Shared definitions for the DoCE transport-layer MAC/ID table: word layout,
// error codes and the configuration master's FSM states.
package doce_mac_tbl_pkg;

  localparam int NUM_WORDS = 13;

  // Word index layout: 0..7 interleaved mac_n_low/mac_n_high, 8..11 ip_n, 12 valid mask
  localparam logic [3:0] IDX_IP0   = 4'd8;
  localparam logic [3:0] IDX_VALID = 4'd12;
  localparam logic [3:0] IDX_LAST  = 4'(NUM_WORDS - 1);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_RESP     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic logic [9:0] word_offset(input logic [9:0] base, input logic [3:0] idx);
    return base + {4'b0000, idx, 2'b00};
  endfunction

endpackage

// File: rtl/mac_tbl_word_sel.sv
// Maps a table word index to its register offset and the data word that
// belongs there, taken from the shadowed node configuration.
module mac_tbl_word_sel
  import doce_mac_tbl_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = 10'h200
) (
  input  logic [3:0]   idx_i,
  input  logic [191:0] mac_i,
  input  logic [127:0] ip_i,
  input  logic [3:0]   valid_i,
  output logic [9:0]   offset_o,
  output logic [31:0]  data_o
);

  logic [47:0] mac_sel;
  logic [31:0] ip_sel;

  always_comb begin
    case (idx_i[2:1])
      2'd0:    mac_sel = mac_i[47:0];
      2'd1:    mac_sel = mac_i[95:48];
      2'd2:    mac_sel = mac_i[143:96];
      default: mac_sel = mac_i[191:144];
    endcase
  end

  always_comb begin
    case (idx_i[1:0])
      2'd0:    ip_sel = ip_i[31:0];
      2'd1:    ip_sel = ip_i[63:32];
      2'd2:    ip_sel = ip_i[95:64];
      default: ip_sel = ip_i[127:96];
    endcase
  end

  always_comb begin
    offset_o = word_offset(BASE_ADDR, idx_i);
    data_o   = '0;
    if (idx_i < IDX_IP0) begin
      // Odd index is the high half of the node's MAC, zero-padded
      data_o = idx_i[0] ? {16'h0000, mac_sel[47:32]} : mac_sel[31:0];
    end else if (idx_i < IDX_VALID) begin
      data_o = ip_sel;
    end else if (idx_i == IDX_VALID) begin
      data_o = {28'h0, valid_i};
    end
  end

endmodule

// File: rtl/mac_table_cfg_master.sv
// AXI-Lite initiator that loads the MAC/ID table (4 nodes + valid mask) on a
// start pulse and optionally reads every word back to confirm it.
module mac_table_cfg_master
  import doce_mac_tbl_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = 10'h200,
  parameter int         TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         verify_en,
  input  logic [191:0] cfg_mac,
  input  logic [127:0] cfg_ip,
  input  logic [3:0]   cfg_valid,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err_code,
  output logic [9:0]   err_addr,
  output logic [2:0]   dbg_state_o,
  output logic [31:0]  m_axi_lite_awaddr,
  output logic         m_axi_lite_awvalid,
  input  logic         m_axi_lite_awready,
  output logic [31:0]  m_axi_lite_wdata,
  output logic [3:0]   m_axi_lite_wstrb,
  output logic         m_axi_lite_wvalid,
  input  logic         m_axi_lite_wready,
  input  logic [1:0]   m_axi_lite_bresp,
  input  logic         m_axi_lite_bvalid,
  output logic         m_axi_lite_bready,
  output logic [31:0]  m_axi_lite_araddr,
  output logic         m_axi_lite_arvalid,
  input  logic         m_axi_lite_arready,
  input  logic [31:0]  m_axi_lite_rdata,
  input  logic [1:0]   m_axi_lite_rresp,
  input  logic         m_axi_lite_rvalid,
  output logic         m_axi_lite_rready
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [1:0]   err_code_q, err_code_d;
  logic [9:0]   err_addr_q, err_addr_d;
  logic [191:0] mac_q;
  logic [127:0] ip_q;
  logic [3:0]   valid_q;
  logic         verify_q;

  logic [9:0]   word_off;
  logic [31:0]  word_data;
  logic         accept;
  logic         timeout;
  logic         last;

  mac_tbl_word_sel #(
    .BASE_ADDR(BASE_ADDR)
  ) u_word_sel (
    .idx_i   (idx_q),
    .mac_i   (mac_q),
    .ip_i    (ip_q),
    .valid_i (valid_q),
    .offset_o(word_off),
    .data_o  (word_data)
  );

  assign accept  = (state_q == IDLE) && start;
  assign timeout = (cnt_q == TO_LAST);
  assign last    = (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valids are raised without looking at ready and held until their
  // own handshake; AW and W are tracked separately and may finish in any order.
  // The only early drop is a timeout abort, which leaves the bus to be reset.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WR_REQ;
          idx_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_code_d = ERR_OK;
          err_addr_d = '0;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | (m_axi_lite_awvalid & m_axi_lite_awready);
        w_done_d  = w_done_q | (m_axi_lite_wvalid & m_axi_lite_wready);
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (timeout) begin
          state_d    = DONE;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = word_off;
        end
      end
      WR_RESP: begin
        if (m_axi_lite_bvalid) begin
          if (m_axi_lite_bresp != 2'b00) begin
            state_d    = DONE;
            err_code_d = ERR_RESP;
            err_addr_d = word_off;
          end else if (last) begin
            state_d = verify_q ? RD_REQ : DONE;
            idx_d   = '0;
          end else begin
            state_d = WR_REQ;
            idx_d   = idx_q + 4'd1;
          end
        end else if (timeout) begin
          state_d    = DONE;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = word_off;
        end
      end
      RD_REQ: begin
        if (m_axi_lite_arready) begin
          state_d = RD_RESP;
        end else if (timeout) begin
          state_d    = DONE;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = word_off;
        end
      end
      RD_RESP: begin
        if (m_axi_lite_rvalid) begin
          if (m_axi_lite_rresp != 2'b00) begin
            state_d    = DONE;
            err_code_d = ERR_RESP;
            err_addr_d = word_off;
          end else if (m_axi_lite_rdata != word_data) begin
            state_d    = DONE;
            err_code_d = ERR_MISMATCH;
            err_addr_d = word_off;
          end else if (last) begin
            state_d = DONE;
          end else begin
            state_d = RD_REQ;
            idx_d   = idx_q + 4'd1;
          end
        end else if (timeout) begin
          state_d    = DONE;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = word_off;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Per-word handshake flags only live while a write request is open
    if (state_d != WR_REQ) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    if (state_d == DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    m_axi_lite_awvalid = (state_q == WR_REQ) && !aw_done_q;
    m_axi_lite_wvalid  = (state_q == WR_REQ) && !w_done_q;
    m_axi_lite_bready  = (state_q == WR_RESP);
    m_axi_lite_arvalid = (state_q == RD_REQ);
    m_axi_lite_rready  = (state_q == RD_RESP);
    m_axi_lite_awaddr  = '0;
    m_axi_lite_wdata   = '0;
    m_axi_lite_wstrb   = '0;
    m_axi_lite_araddr  = '0;
    if (state_q == WR_REQ) begin
      m_axi_lite_awaddr = {22'h0, word_off};
      m_axi_lite_wdata  = word_data;
      m_axi_lite_wstrb  = 4'hF;
    end
    if (state_q == RD_REQ) begin
      m_axi_lite_araddr = {22'h0, word_off};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_code_q <= ERR_OK;
      err_addr_q <= '0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Shadow copy so the caller may change cfg_* while the table is being loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_q    <= '0;
      ip_q     <= '0;
      valid_q  <= '0;
      verify_q <= 1'b0;
    end else if (accept) begin
      mac_q    <= cfg_mac;
      ip_q     <= cfg_ip;
      valid_q  <= cfg_valid;
      verify_q <= verify_en;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_code_q;
  assign err_addr    = err_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_table_cfg_master.sv
// Directed bench for mac_table_cfg_master with a behavioural AXI-Lite table
// slave whose ready timing, response codes and readback can be disturbed.
module tb_mac_table_cfg_master;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         verify_en = 1'b0;
  logic [191:0] cfg_mac = '0;
  logic [127:0] cfg_ip = '0;
  logic [3:0]   cfg_valid = '0;
  logic         busy, done;
  logic [1:0]   err_code;
  logic [9:0]   err_addr;
  logic [2:0]   dbg_state;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_table_cfg_master dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
    .cfg_mac(cfg_mac), .cfg_ip(cfg_ip), .cfg_valid(cfg_valid),
    .busy(busy), .done(done), .err_code(err_code), .err_addr(err_addr),
    .dbg_state_o(dbg_state),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
    .m_axi_lite_rready(rready)
  );

  // Behavioural table slave
  logic [31:0] mem [0:15];
  int          aw_delay = 0;
  int          w_delay = 0;
  logic        aw_block = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int          aw_cnt, w_cnt, b_count;
  logic        got_aw, got_w;
  logic [31:0] aw_addr_l, w_data_l, a_v, d_v;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [31:0] ar_log[$];
  logic [31:0] exp_q[$];

  assign awready = awvalid && !aw_block && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;
  assign bresp   = bresp_val;
  assign rresp   = 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; b_count <= 0;
      aw_log.delete(); w_log.delete(); ar_log.delete();
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (bvalid && bready) begin
        bvalid  <= 1'b0;
        b_count <= b_count + 1;
      end
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready) w_log.push_back(wdata);
      a_v = (awvalid && awready) ? awaddr : aw_addr_l;
      d_v = (wvalid && wready) ? wdata : w_data_l;
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        mem[4'((a_v - 32'h200) >> 2)] <= d_v;
        bvalid <= 1'b1;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        if (awvalid && awready) begin got_aw <= 1'b1; aw_addr_l <= awaddr; end
        if (wvalid && wready)   begin got_w  <= 1'b1; w_data_l  <= wdata;  end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        rdata  <= mem[4'((araddr - 32'h200) >> 2)] ^ ((araddr == corrupt_addr) ? 32'h1 : 32'h0);
        rvalid <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aw_delay = 0; w_delay = 0; aw_block = 1'b0; bresp_val = 2'b00;
    corrupt_addr = 32'hFFFF_FFFF; start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cfg1(input logic verify);
    cfg_mac   = {48'h0A0B0C0D0E04, 48'h0A0B0C0D0E03, 48'h0A0B0C0D0E02, 48'h0A0B0C0D0E01};
    cfg_ip    = {32'hC0A80004, 32'hC0A80003, 32'hC0A80002, 32'hC0A80001};
    cfg_valid = 4'hF;
    verify_en = verify;
  endtask

  // Leaves the caller at the negedge after the edge that accepted start
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_aw_count"}, aw_log.size(), 13);
    chk({tag, "_w_count"}, w_log.size(), 13);
    chk({tag, "_b_count"}, b_count, 13);
    for (int i = 0; i < 13; i++) begin
      if (i < aw_log.size()) chk({tag, "_awaddr"}, aw_log[i], 32'h200 + 32'(4 * i));
      if (i < w_log.size())  chk({tag, "_wdata"}, w_log[i], exp_q[i]);
    end
  endtask

  int cyc;

  initial begin
    exp_q = '{32'h0C0D0E01, 32'h00000A0B, 32'h0C0D0E02, 32'h00000A0B,
              32'h0C0D0E03, 32'h00000A0B, 32'h0C0D0E04, 32'h00000A0B,
              32'hC0A80001, 32'hC0A80002, 32'hC0A80003, 32'hC0A80004, 32'h0000000F};

    // Reset values
    #2;
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_wstrb", wstrb, 0);

    // 1: plain write pass
    do_reset();
    set_cfg1(1'b0);
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_wstrb", wstrb, 4'hF);
    wait_done(200, cyc);
    chk("t1_cycles", cyc, 26);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_err", err_code, 0);
    chk("t1_err_addr", err_addr, 0);
    check_writes("t1");

    // 2: with verify; a start while busy with new config must be ignored
    do_reset();
    set_cfg1(1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    cfg_mac = ~cfg_mac;
    pulse_start();
    wait_done(200, cyc);
    chk("t2_cycles", cyc + 4, 52);
    chk("t2_err", err_code, 0);
    chk("t2_ar_count", ar_log.size(), 13);
    check_writes("t2");

    // 3: readback of 0x214 corrupted
    do_reset();
    set_cfg1(1'b1);
    corrupt_addr = 32'h214;
    pulse_start();
    wait_done(200, cyc);
    chk("t3_cycles", cyc, 38);
    chk("t3_err", err_code, 2);
    chk("t3_err_addr", err_addr, 10'h214);
    repeat (5) @(negedge clk);
    chk("t3_ar_count", ar_log.size(), 6);
    chk("t3_arvalid", arvalid, 0);

    // Bad BRESP on the first word
    do_reset();
    set_cfg1(1'b0);
    bresp_val = 2'b10;
    pulse_start();
    wait_done(50, cyc);
    chk("tb_cycles", cyc, 2);
    chk("tb_err", err_code, 1);
    chk("tb_err_addr", err_addr, 10'h200);
    chk("tb_b_count", b_count, 1);

    // 4: awready stuck low
    do_reset();
    set_cfg1(1'b0);
    aw_block = 1'b1;
    pulse_start();
    wait_done(1500, cyc);
    chk("t4_cycles", cyc, 1024);
    chk("t4_err", err_code, 3);
    chk("t4_err_addr", err_addr, 10'h200);
    chk("t4_awvalid", awvalid, 0);
    chk("t4_aw_count", aw_log.size(), 0);

    // 5: AW accepted 3 cycles before W
    do_reset();
    set_cfg1(1'b0);
    w_delay = 3;
    pulse_start();
    @(negedge clk);
    chk("t5_awvalid_dropped", awvalid, 0);
    chk("t5_wvalid_held", wvalid, 1);
    wait_done(300, cyc);
    chk("t5_cycles", cyc + 1, 65);
    chk("t5_err", err_code, 0);
    check_writes("t5");

    // 6: reset in WR_REQ at idx 5, then a clean rerun
    do_reset();
    set_cfg1(1'b0);
    pulse_start();
    repeat (10) @(negedge clk);
    chk("t6_pre_awaddr", awaddr, 32'h214);
    chk("t6_pre_awvalid", awvalid, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_awaddr", awaddr, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(200, cyc);
    chk("t6_cycles", cyc, 26);
    chk("t6_err", err_code, 0);
    check_writes("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
